// File: rtl/mem_stream_pkg.sv
// Shared widths, stream word layout and FSM state codes for the memory stream writer.
package mem_stream_pkg;

    localparam int TAG_W   = 5;
    localparam int DATA_W  = 40;
    localparam int BX_W    = 3;
    localparam int ADDR_W  = 6;
    localparam int CNT_W   = 7;
    localparam int STATS_W = 16;

    localparam logic [TAG_W-1:0] HDR_TAG = 5'h1F;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1 << ADDR_W);

    localparam logic [0:0] WAIT_HDR = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] payload;
    } stream_word_t;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/mem_stream_dest_cnt.sv
// Per-destination item counter with a sticky overflow flag; the count saturates at one full BX page.
module mem_stream_dest_cnt
    import mem_stream_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overflow
);

    assign full = (count == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (hit) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_stream_writer.sv
// Writes the tagged readout stream into NDEST memories and publishes per-event item counts.
// Optional statistics outputs word_cnt/drop_cnt are enabled by MEM_STREAM_WRITER_STATS_EN.
module mem_stream_writer
    import mem_stream_pkg::*;
#(
    parameter int NDEST = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [TAG_W+DATA_W-1:0] mem_dat_stream,
    input  logic                    valid,
    input  logic                    send_BX,
    output logic [DATA_W-1:0]       wr_data,
    output logic [BX_W+ADDR_W-1:0]  wr_addr,
    output logic [NDEST-1:0]        wr_en,
    output logic [NDEST*CNT_W-1:0]  number_out,
    output logic [BX_W-1:0]         number_bx,
    output logic                    event_done,
    output logic [NDEST-1:0]        overflow,
    output logic                    bad_tag
`ifdef MEM_STREAM_WRITER_STATS_EN
    ,
    output logic [STATS_W-1:0]      word_cnt,
    output logic [STATS_W-1:0]      drop_cnt
`endif
);

    localparam logic [TAG_W-1:0] NDEST_TAG = TAG_W'(NDEST);

    stream_word_t           word;
    logic [0:0]             state;
    logic                   send_bx_q;
    logic [BX_W-1:0]        bx_cur;
    logic                   hdr;
    logic                   in_run;
    logic                   collision;
    logic                   bad_word;
    logic                   word_ok;
    logic [NDEST-1:0]       hit_vec;
    logic [NDEST-1:0]       full_vec;
    logic [NDEST-1:0]       accept_vec;
    logic [ADDR_W-1:0]      sel_addr;
    logic [CNT_W-1:0]       counts [NDEST];
    logic [NDEST*CNT_W-1:0] counts_flat;

    assign word      = mem_dat_stream;
    assign hdr       = send_BX & ~send_bx_q;
    assign in_run    = (state == RUN);
    // A data word that arrives alongside send_BX loses to the header
    assign collision = in_run & valid & send_BX;
    assign bad_word  = in_run & valid & ~send_BX & (word.tag >= NDEST_TAG);
    assign word_ok   = in_run & valid & ~send_BX & (word.tag < NDEST_TAG);

    always_comb begin
        hit_vec  = '0;
        sel_addr = '0;
        for (int i = 0; i < NDEST; i++) begin
            if (word.tag == TAG_W'(i)) begin
                hit_vec[i] = word_ok;
                sel_addr   = counts[i][ADDR_W-1:0];
            end
        end
    end

    assign accept_vec = hit_vec & ~full_vec;

    for (genvar g = 0; g < NDEST; g++) begin : g_dest
        mem_stream_dest_cnt u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clear    (hdr),
            .hit      (hit_vec[g]),
            .count    (counts[g]),
            .full     (full_vec[g]),
            .overflow (overflow[g])
        );
        assign counts_flat[g*CNT_W +: CNT_W] = counts[g];
    end

    // The first header after reset only opens an event; later headers also close the previous one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_HDR;
            send_bx_q  <= 1'b0;
            bx_cur     <= '0;
            wr_en      <= '0;
            wr_data    <= '0;
            wr_addr    <= '0;
            number_out <= '0;
            number_bx  <= '0;
            event_done <= 1'b0;
            bad_tag    <= 1'b0;
        end else begin
            send_bx_q  <= send_BX;
            event_done <= 1'b0;
            wr_en      <= accept_vec;
            if (|accept_vec) begin
                wr_data <= word.payload;
                wr_addr <= {bx_cur, sel_addr};
            end
            if (hdr) begin
                bx_cur <= word.payload[BX_W-1:0];
                state  <= RUN;
                if (in_run) begin
                    number_out <= counts_flat;
                    number_bx  <= bx_cur;
                    event_done <= 1'b1;
                end
            end
            if (collision | bad_word) begin
                bad_tag <= 1'b1;
            end
        end
    end

`ifdef MEM_STREAM_WRITER_STATS_EN
    logic over_drop;
    assign over_drop = |(hit_vec & full_vec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (|accept_vec) begin
                word_cnt <= sat_inc(word_cnt);
            end
            if (collision | bad_word | over_drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stream_writer.sv
// Scoreboard bench for mem_stream_writer: a behavioural model queues expected writes and events.
module tb_mem_stream_writer;
    import mem_stream_pkg::*;

    localparam int NDEST = 12;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [TAG_W+DATA_W-1:0] mem_dat_stream;
    logic                    valid;
    logic                    send_BX;
    logic [DATA_W-1:0]       wr_data;
    logic [BX_W+ADDR_W-1:0]  wr_addr;
    logic [NDEST-1:0]        wr_en;
    logic [NDEST*CNT_W-1:0]  number_out;
    logic [BX_W-1:0]         number_bx;
    logic                    event_done;
    logic [NDEST-1:0]        overflow;
    logic                    bad_tag;
`ifdef MEM_STREAM_WRITER_STATS_EN
    logic [15:0]             word_cnt;
    logic [15:0]             drop_cnt;
`endif

    always #5 clk = ~clk;

    mem_stream_writer #(.NDEST(NDEST)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_dat_stream (mem_dat_stream),
        .valid          (valid),
        .send_BX        (send_BX),
        .wr_data        (wr_data),
        .wr_addr        (wr_addr),
        .wr_en          (wr_en),
        .number_out     (number_out),
        .number_bx      (number_bx),
        .event_done     (event_done),
        .overflow       (overflow),
        .bad_tag        (bad_tag)
`ifdef MEM_STREAM_WRITER_STATS_EN
        ,
        .word_cnt       (word_cnt),
        .drop_cnt       (drop_cnt)
`endif
    );

    typedef struct {
        logic [NDEST-1:0]       en;
        logic [BX_W+ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      data;
    } wr_exp_t;

    typedef struct {
        logic [NDEST*CNT_W-1:0] num;
        logic [BX_W-1:0]        bx;
    } ev_exp_t;

    wr_exp_t wrQ[$];
    ev_exp_t evQ[$];
    wr_exp_t wrItem;
    ev_exp_t evItem;

    int total = 0;
    int bad = 0;
    int eventsSeen = 0;
    int eventsPushed = 0;

    bit               mRun;
    bit               mSendQ;
    logic [BX_W-1:0]  mBx;
    int               mCnt [NDEST];
    logic [NDEST-1:0] mOvf;
    logic             mBad;
    int               mWords;
    int               mDrops;

    task automatic checkOutput(input string name, input logic [95:0] observed, input logic [95:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, observed, expected);
        end
    endtask

    task automatic modelReset();
        mRun   = 1'b0;
        mSendQ = 1'b0;
        mBx    = '0;
        mOvf   = '0;
        mBad   = 1'b0;
        mWords = 0;
        mDrops = 0;
        for (int i = 0; i < NDEST; i++) mCnt[i] = 0;
    endtask

    // Drive one input cycle and advance the model by the edge that samples it
    task automatic applyStimulus(input logic v, input logic s, input logic [TAG_W-1:0] tag,
                                 input logic [DATA_W-1:0] payload);
        bit wasRun;
        logic [NDEST*CNT_W-1:0] flat;
        @(negedge clk);
        valid          = v;
        send_BX        = s;
        mem_dat_stream = {tag, payload};
        wasRun = mRun;
        if (v && wasRun) begin
            if (s) begin
                mBad = 1'b1;
                mDrops++;
            end else if (int'(tag) >= NDEST) begin
                mBad = 1'b1;
                mDrops++;
            end else if (mCnt[tag] < 64) begin
                wrQ.push_back('{NDEST'(1) << tag, {mBx, 6'(mCnt[tag])}, payload});
                mCnt[tag]++;
                mWords++;
            end else begin
                mOvf[tag] = 1'b1;
                mDrops++;
            end
        end
        if (s && !mSendQ) begin
            if (wasRun) begin
                flat = '0;
                for (int i = 0; i < NDEST; i++) flat[i*CNT_W +: CNT_W] = 7'(mCnt[i]);
                evQ.push_back('{flat, mBx});
                eventsPushed++;
            end
            for (int i = 0; i < NDEST; i++) mCnt[i] = 0;
            mBx  = payload[BX_W-1:0];
            mRun = 1'b1;
        end
        mSendQ = s;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic header(input logic [BX_W-1:0] bx);
        applyStimulus(1'b0, 1'b1, HDR_TAG, DATA_W'(bx));
    endtask

    task automatic checkFlags(input string name);
        checkOutput({name, "_overflow"}, overflow, mOvf);
        checkOutput({name, "_bad_tag"}, bad_tag, mBad);
    endtask

    // Output side of the scoreboard: every write and event pulse must match the head of its queue
    always @(negedge clk) begin
        if (wr_en != '0) begin
            if (wrQ.size() == 0) begin
                checkOutput("spurious_wr_en", wr_en, '0);
            end else begin
                wrItem = wrQ.pop_front();
                checkOutput("wr_en", wr_en, wrItem.en);
                checkOutput("wr_addr", wr_addr, wrItem.addr);
                checkOutput("wr_data", wr_data, wrItem.data);
            end
        end
        if (event_done) begin
            eventsSeen++;
            if (evQ.size() == 0) begin
                checkOutput("spurious_event_done", event_done, 1'b0);
            end else begin
                evItem = evQ.pop_front();
                checkOutput("number_out", number_out, evItem.num);
                checkOutput("number_bx", number_bx, evItem.bx);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        valid          = 1'b0;
        send_BX        = 1'b0;
        mem_dat_stream = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_en", wr_en, '0);
        checkOutput("rst_wr_data", wr_data, '0);
        checkOutput("rst_wr_addr", wr_addr, '0);
        checkOutput("rst_number_out", number_out, '0);
        checkOutput("rst_number_bx", number_bx, '0);
        checkOutput("rst_event_done", event_done, 1'b0);
        checkOutput("rst_overflow", overflow, '0);
        checkOutput("rst_bad_tag", bad_tag, 1'b0);
        reset = 1'b0;

        // Words before the first header are discarded without flags
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'd3, DATA_W'(32'h300 + i));
        idle(2);
        checkFlags("pre_hdr");
        header(3'd5);
        idle(2);

        header(3'd2);
        applyStimulus(1'b1, 1'b0, 5'd0, 40'hA0);
        applyStimulus(1'b1, 1'b0, 5'd0, 40'hA1);
        applyStimulus(1'b1, 1'b0, 5'd7, 40'hB0);
        header(3'd3);
        idle(2);
        checkOutput("evt_num0", number_out[0 +: 7], 7'd2);
        checkOutput("evt_num7", number_out[49 +: 7], 7'd1);
        checkOutput("evt_bx", number_bx, 3'd2);

        // Held send_BX must produce exactly one header
        repeat (10) header(3'd4);
        idle(2);

        for (int i = 0; i < 66; i++) applyStimulus(1'b1, 1'b0, 5'd11, DATA_W'($urandom));
        idle(2);
        checkFlags("ovf");
        header(3'd6);
        idle(2);
        checkOutput("evt_num11", number_out[77 +: 7], 7'd64);

        applyStimulus(1'b1, 1'b0, 5'd2, 40'hC2);
        applyStimulus(1'b1, 1'b0, 5'd12, 40'hD0);
        applyStimulus(1'b1, 1'b0, 5'd31, 40'hD1);
        idle(1);
        applyStimulus(1'b1, 1'b1, 5'd0, 40'h7);
        idle(2);
        checkFlags("badtag");
        checkOutput("evt_num2", number_out[14 +: 7], 7'd1);

`ifdef MEM_STREAM_WRITER_STATS_EN
        checkOutput("word_cnt", word_cnt, 16'(mWords));
        checkOutput("drop_cnt", drop_cnt, 16'(mDrops));
`endif

        header(3'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 5'd4, DATA_W'(32'h400 + i));
        idle(2);
        reset = 1'b1;
        modelReset();
        idle(1);
        checkOutput("mid_rst_number_out", number_out, '0);
        checkOutput("mid_rst_number_bx", number_bx, '0);
        checkOutput("mid_rst_wr_en", wr_en, '0);
        checkFlags("mid_rst");
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 5'd5, 40'hE0);
        applyStimulus(1'b1, 1'b0, 5'd5, 40'hE1);
        idle(1);
        header(3'd3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'd5, DATA_W'(32'hF0 + i));
        header(3'd4);
        idle(3);
        checkOutput("post_rst_num5", number_out[35 +: 7], 7'd3);
        checkOutput("post_rst_num4", number_out[28 +: 7], 7'd0);
        checkOutput("post_rst_bx", number_bx, 3'd3);

        checkOutput("wr_queue_empty", 96'(wrQ.size()), '0);
        checkOutput("ev_queue_empty", 96'(evQ.size()), '0);
        checkOutput("event_count", 96'(eventsSeen), 96'(eventsPushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
